sys_cntr_tx: RTL and testbench



---
 rtl/sys_cntr_tx.sv | 103 ++++++++++
 tb/tb_sys_cntr_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sys_cntr_tx.sv
// Transmit-side controller: captures RegFile read data or ALU results and
// pushes them LSB byte first into the TX FIFO write port.
module sys_cntr_tx #(
    parameter int unsigned width = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [width-1:0]   RdData,
    input  logic               RdData_Valid,
    input  logic [2*width-1:0] ALU_OUT,
    input  logic               OUT_Valid,
    input  logic               FIFO_FULL,
    output logic [width-1:0]   FIFO_WR_DATA,
    output logic               FIFO_WR_INC,
    output logic               Busy,
    output logic               Overrun
);

    typedef enum logic [1:0] {
        StIdle,
        StSendRd,
        StSendLo,
        StSendHi
    } state_e;

    state_e             state_q;
    logic [2*width-1:0] cap_q;
    logic               overrun_q;
    logic               any_valid;

    assign any_valid = RdData_Valid | OUT_Valid;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cap_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (RdData_Valid) begin
                        // Read data wins a same-cycle collision; the ALU result is dropped.
                        cap_q[width-1:0] <= RdData;
                        state_q          <= StSendRd;
                        overrun_q        <= OUT_Valid;
                    end else if (OUT_Valid) begin
                        cap_q   <= ALU_OUT;
                        state_q <= StSendLo;
                    end
                end
                StSendRd: begin
                    overrun_q <= any_valid;
                    if (!FIFO_FULL) begin
                        state_q <= StIdle;
                    end
                end
                StSendLo: begin
                    overrun_q <= any_valid;
                    if (!FIFO_FULL) begin
                        state_q <= StSendHi;
                    end
                end
                StSendHi: begin
                    overrun_q <= any_valid;
                    if (!FIFO_FULL) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Push strobe is combinational so it follows FIFO_FULL within the cycle.
    always_comb begin
        FIFO_WR_DATA = '0;
        FIFO_WR_INC  = 1'b0;
        Busy         = 1'b0;
        case (state_q)
            StSendRd, StSendLo: begin
                FIFO_WR_DATA = cap_q[width-1:0];
                FIFO_WR_INC  = !FIFO_FULL;
                Busy         = 1'b1;
            end
            StSendHi: begin
                FIFO_WR_DATA = cap_q[2*width-1:width];
                FIFO_WR_INC  = !FIFO_FULL;
                Busy         = 1'b1;
            end
            default: begin
                FIFO_WR_DATA = '0;
                FIFO_WR_INC  = 1'b0;
                Busy         = 1'b0;
            end
        endcase
    end

    assign Overrun = overrun_q;

endmodule

// File: tb/tb_sys_cntr_tx.sv
// Bench for sys_cntr_tx: a byte-queue model checked every cycle plus
// directed scenarios with hand-computed push sequences.
module tb_sys_cntr_tx;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [7:0]  FIFO_WR_DATA;
    logic        FIFO_WR_INC;
    logic        Busy;
    logic        Overrun;

    int errors = 0;
    int checks = 0;

    sys_cntr_tx #(.width(8)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .FIFO_FULL    (FIFO_FULL),
        .FIFO_WR_DATA (FIFO_WR_DATA),
        .FIFO_WR_INC  (FIFO_WR_INC),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes still owed to the FIFO; busy whenever any remain.
    logic [7:0] pend[$];
    bit         m_ovr = 1'b0;
    bit         m_busy;

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pend.delete();
            m_ovr = 1'b0;
        end else begin
            m_busy = (pend.size() != 0);
            m_ovr  = m_busy ? (RdData_Valid || OUT_Valid) : (RdData_Valid && OUT_Valid);
            if (m_busy) begin
                if (!FIFO_FULL) void'(pend.pop_front());
            end else if (RdData_Valid) begin
                pend.push_back(RdData);
            end else if (OUT_Valid) begin
                pend.push_back(ALU_OUT[7:0]);
                pend.push_back(ALU_OUT[15:8]);
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge CLK) begin
        check("busy", {31'b0, Busy}, {31'b0, pend.size() != 0});
        check("wr_inc", {31'b0, FIFO_WR_INC}, {31'b0, (pend.size() != 0) && !FIFO_FULL});
        check("wr_data", {24'b0, FIFO_WR_DATA}, (pend.size() != 0) ? {24'b0, pend[0]} : 32'h0);
        check("overrun", {31'b0, Overrun}, {31'b0, m_ovr});
    end

    // Observed pushes and activity counters for the directed checks.
    logic [7:0] log_q[$];
    int         busy_cnt = 0;
    int         ovr_cnt = 0;

    always @(negedge CLK) begin
        if (Reset && FIFO_WR_INC) log_q.push_back(FIFO_WR_DATA);
        if (Busy) busy_cnt++;
        if (Overrun) ovr_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        busy_cnt = 0;
        ovr_cnt  = 0;
    endtask

    initial begin
        tick(2);
        check("rst_busy", {31'b0, Busy}, 32'h0);
        check("rst_inc", {31'b0, FIFO_WR_INC}, 32'h0);
        check("rst_data", {24'b0, FIFO_WR_DATA}, 32'h0);
        check("rst_ovr", {31'b0, Overrun}, 32'h0);
        Reset = 1'b1;
        tick(2);

        // Single read byte.
        clear_logs();
        RdData = 8'h5A; RdData_Valid = 1'b1;
        tick(1);
        RdData_Valid = 1'b0;
        tick(4);
        check("rd_cnt", log_q.size(), 1);
        check("rd_b0", {24'b0, log_q[0]}, 32'h5A);
        check("rd_busy", busy_cnt, 1);
        check("rd_ovr", ovr_cnt, 0);

        // ALU result, LSB first.
        clear_logs();
        ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
        tick(1);
        OUT_Valid = 1'b0;
        tick(4);
        check("alu_cnt", log_q.size(), 2);
        check("alu_b0", {24'b0, log_q[0]}, 32'h34);
        check("alu_b1", {24'b0, log_q[1]}, 32'h12);
        check("alu_busy", busy_cnt, 2);

        // Backpressure: FIFO full for 3 cycles after capture.
        clear_logs();
        ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
        tick(1);
        OUT_Valid = 1'b0; FIFO_FULL = 1'b1;
        tick(3);
        FIFO_FULL = 1'b0;
        tick(4);
        check("bp_cnt", log_q.size(), 2);
        check("bp_b0", {24'b0, log_q[0]}, 32'hEF);
        check("bp_b1", {24'b0, log_q[1]}, 32'hBE);
        check("bp_busy", busy_cnt, 5);

        // Simultaneous valids: read wins, ALU dropped.
        clear_logs();
        RdData = 8'h77; RdData_Valid = 1'b1; ALU_OUT = 16'hAAAA; OUT_Valid = 1'b1;
        tick(1);
        RdData_Valid = 1'b0; OUT_Valid = 1'b0;
        tick(4);
        check("col_cnt", log_q.size(), 1);
        check("col_b0", {24'b0, log_q[0]}, 32'h77);
        check("col_ovr", ovr_cnt, 1);

        // Valid while busy is dropped; capture untouched.
        clear_logs();
        ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
        tick(1);
        ALU_OUT = 16'h0102;
        tick(1);
        OUT_Valid = 1'b0;
        tick(4);
        check("busy_cnt", log_q.size(), 2);
        check("busy_b0", {24'b0, log_q[0]}, 32'h34);
        check("busy_b1", {24'b0, log_q[1]}, 32'h12);
        check("busy_ovr", ovr_cnt, 1);

        // Reset between LO and HI pushes.
        clear_logs();
        ALU_OUT = 16'hCAFE; OUT_Valid = 1'b1;
        tick(1);
        OUT_Valid = 1'b0;
        tick(1);
        Reset = 1'b0;
        #1;
        check("ar_busy", {31'b0, Busy}, 32'h0);
        check("ar_inc", {31'b0, FIFO_WR_INC}, 32'h0);
        check("ar_data", {24'b0, FIFO_WR_DATA}, 32'h0);
        check("ar_ovr", {31'b0, Overrun}, 32'h0);
        tick(2);
        Reset = 1'b1;
        tick(4);
        check("ar_cnt", log_q.size(), 1);
        check("ar_b0", {24'b0, log_q[0]}, 32'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
